// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_bus_ctrl_pkg;

  localparam int TO_W = 8;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Bus-wait counter: counts BUSY cycles and flags the last permitted cycle.
module dmem_timeout_cnt
  import dmem_bus_ctrl_pkg::*;
#(
  parameter logic [TO_W-1:0] TC_VAL = 8'd254
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [TO_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Runs the M-stage load/store as a req/ack bus transaction and returns
// data_mem_ack to the hazard unit; a bounded wait protects against dead slaves.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic [3:0]  byte_en_M,
  input  logic        pipe_hold,
  output logic [31:0] read_data_M,
  output logic        data_mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

  state_t      r_state, w_next_state;
  logic        w_strobe, w_accept, w_busy, w_tc;
  logic        w_ack_hit, w_timeout, w_complete, w_cnt_clr;
  logic        r_bus_req, r_bus_we, r_bus_err;
  logic [31:0] r_bus_addr, r_bus_wdata, r_read_data;
  logic [3:0]  r_bus_be;

  assign w_strobe   = mem_read_M | mem_write_M;
  assign w_accept   = (r_state == ST_IDLE) && w_strobe;
  assign w_busy     = (r_state == ST_BUSY);
  assign w_ack_hit  = w_busy && bus_ack;
  // A late ack on the terminal cycle still counts as a good completion.
  assign w_timeout  = w_busy && !bus_ack && w_tc;
  assign w_complete = w_ack_hit || w_timeout;
  assign w_cnt_clr  = !w_busy || w_complete;

  dmem_timeout_cnt #(
    .TC_VAL (TC_VAL)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_busy),
    .o_tc  (w_tc)
  );

  always_comb begin
    // NOTE: next-state gets a default first so no path through the case can infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_strobe) w_next_state = ST_BUSY;
      // A flushed M stage skips DONE so the ack never reaches an unrelated instruction.
      ST_BUSY: if (w_complete) w_next_state = w_strobe ? ST_DONE : ST_IDLE;
      ST_DONE: if (!pipe_hold) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bus_req <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bus_req <= (w_next_state == ST_BUSY);
    end
  end

  // Bus command is captured once at accept and held for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
    end else if (w_accept) begin
      r_bus_we    <= mem_write_M;
      r_bus_addr  <= word_align(alu_out_M);
      r_bus_wdata <= write_data_M;
      r_bus_be    <= byte_en_M;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_data <= '0;
    end else if (!r_bus_we) begin
      if (w_ack_hit) begin
        r_read_data <= bus_rdata;
      end else if (w_timeout) begin
        r_read_data <= ERR_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign data_mem_ack = (r_state == ST_DONE);
  assign read_data_M  = r_read_data;
  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_be       = r_bus_be;
  assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: stimulus queues expected bus commands
// and M-stage acks; negedge monitors pop and compare as the DUT presents them.
module tb_dmem_bus_ctrl;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } bus_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_M, mem_write_M, pipe_hold, bus_ack, err_clr;
  logic [31:0] alu_out_M, write_data_M, bus_rdata;
  logic [3:0]  byte_en_M;
  logic [31:0] read_data_M, bus_addr, bus_wdata;
  logic        data_mem_ack, bus_req, bus_we, bus_err;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];

  dmem_bus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read_M   (mem_read_M),
    .mem_write_M  (mem_write_M),
    .alu_out_M    (alu_out_M),
    .write_data_M (write_data_M),
    .byte_en_M    (byte_en_M),
    .pipe_hold    (pipe_hold),
    .read_data_M  (read_data_M),
    .data_mem_ack (data_mem_ack),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bus_req"},      32'(bus_req),      32'd0);
    check({tag, "_bus_we"},       32'(bus_we),       32'd0);
    check({tag, "_bus_addr"},     bus_addr,          32'd0);
    check({tag, "_bus_wdata"},    bus_wdata,         32'd0);
    check({tag, "_bus_be"},       32'(bus_be),       32'd0);
    check({tag, "_read_data_M"},  read_data_M,       32'd0);
    check({tag, "_data_mem_ack"}, 32'(data_mem_ack), 32'd0);
    check({tag, "_bus_err"},      32'(bus_err),      32'd0);
  endtask

  // Called at #1 into an IDLE cycle; returns at #1 into the IDLE cycle after DONE.
  // ack_dly = cycles between first bus_req cycle and the bus_ack cycle.
  // hold = number of cycles data_mem_ack must stay high (pipe_hold stretches DONE).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int ack_dly,
                           input logic [31:0] rdata, input logic [31:0] exp_rd, input int hold);
    bus_exp_t b;
    ack_exp_t a;
    int c0;
    int n_ack;
    c0    = cyc;
    n_ack = (hold < 1) ? 1 : hold;
    b.cyc = c0 + 1; b.we = wr; b.addr = addr & 32'hFFFF_FFFC;
    b.wdata = wdata; b.be = be; b.len = ack_dly + 1;
    bus_q.push_back(b);
    for (int k = 0; k < n_ack; k++) begin
      a.cyc = c0 + 2 + ack_dly + k; a.rdata = exp_rd; a.err = 1'b0;
      ack_q.push_back(a);
    end
    mem_read_M = rd; mem_write_M = wr; alu_out_M = addr;
    write_data_M = wdata; byte_en_M = be;
    step();
    repeat (ack_dly) step();
    bus_ack = 1'b1; bus_rdata = rdata; pipe_hold = (n_ack > 1);
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    for (int j = 1; j <= n_ack; j++) begin
      pipe_hold = (j < n_ack);
      step();
    end
    mem_read_M = 1'b0; mem_write_M = 1'b0; pipe_hold = 1'b0;
  endtask

  // Bus monitor: command fields at bus_req rise, held address, request length.
  logic     prev_req = 1'b0;
  bit       bus_active = 1'b0;
  int       bus_start = 0;
  bus_exp_t cur_bus;

  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        check("bus_req_unexpected", 32'(bus_req), 32'd0);
      end else begin
        cur_bus    = bus_q.pop_front();
        bus_active = 1'b1;
        bus_start  = cyc;
        check("bus_req_cycle", 32'(cyc), 32'(cur_bus.cyc));
        check("bus_we", 32'(bus_we), 32'(cur_bus.we));
        check("bus_addr", bus_addr, cur_bus.addr);
        check("bus_be", 32'(bus_be), 32'(cur_bus.be));
        if (cur_bus.we) check("bus_wdata", bus_wdata, cur_bus.wdata);
      end
    end else if (bus_req && bus_active) begin
      check("bus_addr_held", bus_addr, cur_bus.addr);
    end else if (!bus_req && prev_req && bus_active) begin
      check("bus_req_len", 32'(cyc - bus_start), 32'(cur_bus.len));
      bus_active = 1'b0;
    end
    prev_req = bus_req;
  end

  // Ack monitor: every data_mem_ack cycle must match a queued expectation.
  always @(negedge clk) begin
    ack_exp_t e;
    while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
      check("ack_missing_cycle", 32'(cyc), 32'(ack_q[0].cyc));
      void'(ack_q.pop_front());
    end
    if (data_mem_ack) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 32'(data_mem_ack), 32'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("read_data_M", read_data_M, e.rdata);
        check("bus_err_at_ack", 32'(bus_err), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_exp_t b;
    ack_exp_t a;
    int c0;

    reset = 1'b0; mem_read_M = 1'b0; mem_write_M = 1'b0; pipe_hold = 1'b0;
    bus_ack = 1'b0; err_clr = 1'b0; alu_out_M = '0; write_data_M = '0;
    bus_rdata = '0; byte_en_M = '0;
    repeat (3) step();
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) step();

    // Load, slave acks 2 cycles after bus_req: ack 4 cycles after request.
    do_access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
    step();

    // Stray bus_ack while IDLE must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    step();
    check("idle_ack_ignored", read_data_M, 32'hCAFE_F00D);

    // Byte store at unaligned address, zero-wait slave.
    do_access(1'b0, 1'b1, 32'h0000_2003, 32'h7777_7777, 4'b1000, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    // Both strobes: write wins, read data untouched by the write ack.
    do_access(1'b1, 1'b1, 32'h0000_300A, 32'h1234_5678, 4'b0011, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
    step();

    // pipe_hold stretches DONE to 3 ack cycles, then back-to-back load.
    do_access(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 1, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 3);
    do_access(1'b1, 1'b0, 32'h0000_4004, 32'h0, 4'hF, 0, 32'h55AA_55AA, 32'h55AA_55AA, 0);
    step();

    // Dead slave: 255 request cycles, ERR_DATA, bus_err; err_clr on the
    // terminal cycle loses to the set.
    c0 = cyc;
    b.cyc = c0 + 1; b.we = 1'b0; b.addr = 32'h0000_5000; b.wdata = '0; b.be = 4'hF; b.len = 255;
    bus_q.push_back(b);
    a.cyc = c0 + 256; a.rdata = 32'h0000_0000; a.err = 1'b1;
    ack_q.push_back(a);
    mem_read_M = 1'b1; alu_out_M = 32'h0000_5000; byte_en_M = 4'hF;
    repeat (255) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    mem_read_M = 1'b0;
    step();
    check("bus_err_sticky", 32'(bus_err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("bus_err_cleared", 32'(bus_err), 32'd0);
    step();

    // Flush during BUSY: transaction completes, no ack, back to IDLE.
    c0 = cyc;
    b.cyc = c0 + 1; b.we = 1'b0; b.addr = 32'h0000_6000; b.wdata = '0; b.be = 4'hF; b.len = 3;
    bus_q.push_back(b);
    mem_read_M = 1'b1; alu_out_M = 32'h0000_6000; byte_en_M = 4'hF;
    step();
    step();
    mem_read_M = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0; bus_rdata = 32'h0;

    // Store accepted at once (proves IDLE), then reset lands mid-BUSY.
    c0 = cyc;
    b.cyc = c0 + 1; b.we = 1'b1; b.addr = 32'h0000_7000; b.wdata = 32'hA5A5_A5A5; b.be = 4'hF; b.len = 1;
    bus_q.push_back(b);
    mem_write_M = 1'b1; alu_out_M = 32'h0000_7000; write_data_M = 32'hA5A5_A5A5; byte_en_M = 4'hF;
    step();
    step();
    reset = 1'b0;
    #1;
    check_outputs_zero("midbusy_reset");
    mem_write_M = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // Recovery after reset.
    do_access(1'b1, 1'b0, 32'h0000_8008, 32'h0, 4'hF, 0, 32'h89AB_CDEF, 32'h89AB_CDEF, 0);
    repeat (3) step();

    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
